// File: rtl/alu_resp_sequencer.sv
// Command-to-response sequencer: issues one command to the shared registered ALU,
// waits out its latency, then streams the response packet byte-by-byte to the TX path.
module alu_resp_sequencer #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter logic [7:0]  OpAdd       = 8'h01,
  parameter logic [7:0]  OpMul       = 8'h02,
  parameter logic [7:0]  OpDiv       = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_opcode_i,
  input  logic [31:0] cmd_rs1_i,
  input  logic [31:0] cmd_rs2_i,
  output logic [7:0]  alu_opcode_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  input  logic [63:0] alu_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] result_q, result_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] data2_q, data2_d;
  logic        err_q, err_d;

  logic        cmd_supported;
  logic        is_mul;
  logic [3:0]  last_idx;
  logic [15:0] pkt_len;
  logic [2:0]  byte_sel;

  assign cmd_supported = (cmd_opcode_i == OpAdd) || (cmd_opcode_i == OpMul) ||
                         (cmd_opcode_i == OpDiv);

  // Packet shape follows the opcode held on the ALU port for the whole transaction.
  assign is_mul   = (op_q == OpMul);
  assign last_idx = is_mul ? 4'd11 : 4'd7;
  assign pkt_len  = is_mul ? 16'd12 : 16'd8;
  // Payload byte number (idx - 4), only meaningful for idx >= 4.
  assign byte_sel = idx_q[2:0] - 3'd4;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    result_d = result_q;
    op_d     = op_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_supported) begin
            op_d    = cmd_opcode_i;
            data1_d = cmd_rs1_i;
            data2_d = cmd_rs2_i;
            cnt_d   = 4'(ALU_LATENCY);
            state_d = StWait;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          result_d = alu_data_i;
          idx_d    = 4'd0;
          state_d  = StSend;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSend: begin
        if (tx_ready_i) begin
          if (idx_q == last_idx) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= 4'd0;
      result_q <= 64'd0;
      op_q     <= 8'd0;
      data1_q  <= 32'd0;
      data2_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      op_q     <= op_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == StSend) begin
      case (idx_q)
        4'd0:    tx_data_o = op_q;
        4'd1:    tx_data_o = 8'h00;
        4'd2:    tx_data_o = pkt_len[7:0];
        4'd3:    tx_data_o = pkt_len[15:8];
        default: tx_data_o = result_q[{byte_sel, 3'b000} +: 8];
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign tx_valid_o   = (state_q == StSend);
  assign err_o        = err_q;
  assign alu_opcode_o = op_q;
  assign alu_data1_o  = data1_q;
  assign alu_data2_o  = data2_q;

endmodule

// File: doc/alu_resp_sequencer.md
# alu_resp_sequencer

Controller sitting between the UART packet FSM and the UART transmitter. It accepts one decoded command (opcode plus two 32-bit operands) at a time and drives the shared registered ALU with stable operands. It waits a fixed ALU latency, captures the result, then serializes a complete response packet byte-by-byte over a ready/valid stream to the TX path. It is the only block that issues work to the ALU; the packet FSM never drives the ALU directly.

## Interface

- ALU_LATENCY, 1: rising edges from the ALU inputs changing to `alu_data_i` being valid; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- cmd_valid_i  in  1  command available from packet FSM.
- cmd_ready_o  out  1  sequencer idle, command accepted when both high.
- cmd_opcode_i  in  8  opcode: config_pkg ADD, MUL or DIV.
- cmd_rs1_i  in  32  operand 1.
- cmd_rs2_i  in  32  operand 2.
- alu_opcode_o  out  8  registered opcode to ALU.
- alu_data1_o  out  32  registered operand 1 to ALU.
- alu_data2_o  out  32  registered operand 2 to ALU.
- alu_data_i  in  64  ALU result.
- tx_data_o  out  8  response byte.
- tx_valid_o  out  1  response byte valid.
- tx_ready_i  in  1  TX path accepts byte.
- busy_o  out  1  high whenever not IDLE.
- err_o  out  1  one-cycle pulse on an unsupported opcode.

## Operation

- States: IDLE, WAIT, SEND.
- IDLE: cmd_ready_o=1. On an accepted command with a supported opcode:
  - register opcode and operands onto the alu_* outputs;
  - load the wait counter with ALU_LATENCY;
  - go to WAIT.
- IDLE, unsupported opcode: the command is consumed. err_o pulses high for the next cycle only. State stays IDLE and the alu_* outputs are unchanged.
- WAIT: the alu_* outputs are held stable. The counter decrements each cycle. On the edge where the counter is 0:
  - capture alu_data_i into the 64-bit result register;
  - clear the byte index to 0;
  - go to SEND.
- SEND: emits the response packet. Byte index i selects the byte:
  - i=0: opcode.
  - i=1: 0x00 (reserved).
  - i=2: length LSB.
  - i=3: length MSB.
  - i≥4: result bytes, little-endian (result[7:0] first).
- Payload size is 4 bytes for ADD and DIV (result[31:0]) and 8 bytes for MUL (result[63:0]).
- Length field is 4 + payload: 0x0008 for ADD/DIV, 0x000C for MUL.
- The byte index advances only on tx_valid_o & tx_ready_i.
- The transfer of the last byte (i=7 or i=11) returns the state to IDLE.
- The result register is not modified during SEND, so later ALU input changes have no effect.
- Division by zero and overflow: the ALU result is forwarded unmodified; no error is raised.
- 16-bit length arithmetic; the byte index is 4 bits and never wraps within a packet.

## Timing

- Reset values: cmd_ready_o=1, tx_valid_o=0, tx_data_o=0x00, busy_o=0, err_o=0, alu_opcode_o/alu_data1_o/alu_data2_o=0. State is IDLE.
- Reset asserted mid-packet: all outputs return to their reset values immediately (asynchronously). The partial packet is abandoned and no byte is re-sent after release.
- cmd_ready_o and busy_o are decoded from state; cmd_ready_o = (state==IDLE).
- The command is accepted at edge E0, and the alu_* outputs are valid after E0.
- The result is captured at edge E0+ALU_LATENCY+1.
- tx_valid_o rises after that edge, so the first byte is offered at cycle E0+ALU_LATENCY+2.
- With tx_ready_i held high, one byte transfers per cycle. A packet occupies 8 (ADD/DIV) or 12 (MUL) consecutive cycles.
- While tx_valid_o=1 and tx_ready_i=0, tx_data_o is held stable and tx_valid_o is not withdrawn.
- After the last-byte transfer, tx_valid_o=0 and cmd_ready_o=1 in the next cycle. The earliest next acceptance is at that cycle's edge, giving a minimum of one idle cycle between packets.
- cmd_valid_i while busy is ignored; the command is not consumed and the packet FSM must hold it.

## Test plan

- ADD, rs1=0x00000005, rs2=0x00000007, ALU_LATENCY=1, tx_ready_i=1 -> bytes A0op,00,08,00,0C,00,00,00 (opcode first). First tx_valid_o at E0+3 (edge-relative). cmd_ready_o=1 one cycle after the last byte.
- MUL, rs1=0xFFFFFFFF, rs2=0x00000002 -> length 0x0C,0x00, then payload FE,FF,FF,FF,01,00,00,00; 12 bytes total.
- Backpressure: tx_ready_i toggled randomly during a DIV packet -> no byte dropped or duplicated, tx_data_o stable while stalled, sequence matches the unstalled case.
- Unsupported opcode 0x55 with cmd_valid_i=1 -> err_o high for exactly one cycle, alu_* outputs unchanged, no tx_valid_o, cmd_ready_o stays 1.
- Reset (rst=0) asserted after the 5th byte of a MUL packet -> tx_valid_o drops in the same cycle without waiting for an edge. After release, cmd_ready_o=1 and a fresh ADD command produces a complete correct packet.
- Command presented while busy, and changing operands on alu_data_i after capture -> the busy-time command is not accepted, and the transmitted payload equals the value captured at E0+ALU_LATENCY+1.
